// File: rtl/mux_pkg.sv
// Shared definitions for the flow-controlled multiplexer family:
// mode encodings and the rotating-priority index helper.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Channel reached by stepping 'offset' places past 'base', wrapping at nch.
    function automatic int rr_index(input int base, input int offset, input int nch);
        return (base + offset) % nch;
    endfunction

endpackage

// File: rtl/mux_rr_n_if.sv
// Producer/consumer bundle of mux_rr_n: N input handshakes, select controls
// and the single registered output handshake.
interface mux_rr_n_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH-1:0]         in_valid;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_ch;
    logic                   out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority request scan: picks the first requester after ptr,
// wrapping around, so the channel served last has lowest priority.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    // Scan farthest-first so the nearest requester after ptr overwrites the rest.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (req[rr_index(int'(ptr), k, NCH)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(rr_index(int'(ptr), k, NCH));
            end
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel registered multiplexer with valid/ready on every side; channel
// chosen by external select or by fair round-robin rotation.
module mux_rr_n
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic       clk,
    input  logic       rst,
    mux_rr_n_if.slave  bus
);

    logic [SELW-1:0]  ptr_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_ch_reg;

    logic             rr_valid;
    logic [SELW-1:0]  rr_idx;
    logic             sel_ok;
    logic             dir_valid;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic             load_en;
    logic [WIDTH-1:0] chan_data [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
            // Gated by rst so nothing is accepted while reset is held.
            assign bus.in_ready[gi] = !rst && load_en && grant_valid
                                      && (int'(grant_idx) == gi);
        end
    endgenerate

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (bus.in_valid),
        .ptr       (ptr_reg),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Out-of-range selects (non power-of-two NCH) must never grant.
    assign sel_ok      = int'(bus.sel) < NCH;
    assign dir_valid   = sel_ok && bus.in_valid[bus.sel];
    assign grant_valid = (bus.mode == MODE_RR) ? rr_valid : dir_valid;
    assign grant_idx   = (bus.mode == MODE_RR) ? rr_idx   : bus.sel;
    assign load_en     = !out_valid_reg || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= SELW'(NCH - 1);
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= chan_data[grant_idx];
                out_ch_reg    <= grant_idx;
                if (bus.mode == MODE_RR) begin
                    ptr_reg <= grant_idx;
                end
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mux_rr_n.sv
// Randomised and directed checks of mux_rr_n against a transaction-level
// reference model of its selection and output-register behaviour.
module tb_mux_rr_n;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference state: held word and the last round-robin winner.
    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_ptr;

    mux_rr_n_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    mux_rr_n #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = NCH - 1;
    endtask

    // Which channel should win right now, from the current bus inputs.
    task automatic model_grant(output bit ok, output int g);
        ok = 0; g = 0;
        if (bus.mode == 1'b0) begin
            if (int'(bus.sel) < NCH && bus.in_valid[bus.sel]) begin
                ok = 1; g = int'(bus.sel);
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (bus.in_valid[c]) begin
                    ok = 1; g = c;
                    break;
                end
            end
        end
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check outputs.
    task automatic step(input string tag);
        bit ok; int g; bit load; logic [3:0] exp_rdy;
        model_grant(ok, g);
        load    = !m_valid || bus.out_ready;
        exp_rdy = (load && ok) ? 4'(1 << g) : 4'b0000;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (load) begin
            if (ok) begin
                m_valid = 1; m_data = bus.in_data[g*WIDTH +: WIDTH]; m_ch = g;
                if (bus.mode == 1'b1) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
        check({tag, ".out_ch"},    32'(bus.out_ch),    32'(m_ch));
        $display("%s mode=%0d sel=%0d vld=%b rdy=%b -> in_ready=%b out_v=%0d data=%02h ch=%0d",
                 tag, bus.mode, bus.sel, bus.in_valid, bus.out_ready, bus.in_ready,
                 bus.out_valid, bus.out_data, bus.out_ch);
    endtask

    initial begin
        model_reset();
        bus.mode = 1'b1; bus.sel = '0; bus.in_valid = 4'b1111;
        bus.in_data = {8'h04, 8'h03, 8'h02, 8'h01}; bus.out_ready = 1'b1;

        // Reset held with every channel requesting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst.in_ready", 32'(bus.in_ready), 32'h0);
            check("rst.out_valid", 32'(bus.out_valid), 32'h0);
            check("rst.out_data", 32'(bus.out_data), 32'h0);
            check("rst.out_ch", 32'(bus.out_ch), 32'h0);
        end
        @(posedge clk); #1; rst = 1'b0;
        step("first_rr");

        // Direct mode, sel=2.
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b0100;
        bus.in_data = {8'h00, 8'hC3, 8'h00, 8'h00};
        step("direct_sel2");
        check("direct_sel2.word", 32'(bus.out_data), 32'hC3);
        bus.in_valid = 4'b1011;
        step("direct_sel2_invalid");

        // Round-robin sweep over all valid channels.
        bus.mode = 1'b1; bus.in_valid = 4'b1111;
        bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 5; i++) step("rr_sweep");

        // Wrap-around with only channels 1 and 2 requesting.
        bus.in_valid = 4'b0110;
        for (int i = 0; i < 3; i++) step("rr_wrap");

        // Back-pressure on a held word.
        bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b0010;
        bus.in_data = {8'h00, 8'h00, 8'hAA, 8'h00};
        step("bp_load");
        bus.out_ready = 1'b0; bus.in_valid = 4'b1111; bus.mode = 1'b1;
        for (int i = 0; i < 3; i++) step("bp_hold");
        check("bp_hold.word", 32'(bus.out_data), 32'hAA);
        bus.out_ready = 1'b1; bus.mode = 1'b0; bus.in_valid = 4'b0010;
        bus.in_data = {8'h00, 8'h00, 8'h55, 8'h00};
        step("bp_release");
        check("bp_release.word", 32'(bus.out_data), 32'h55);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            bus.mode      = 1'($urandom_range(0, 1));
            bus.sel       = 2'($urandom_range(0, 3));
            bus.in_valid  = 4'($urandom);
            bus.in_data   = 32'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        // Async reset pulsed between edges while a word is held.
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        bus.in_data = {8'h23, 8'h22, 8'h21, 8'h20};
        step("pre_rst");
        step("pre_rst_hold");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst.out_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst.in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        bus.out_ready = 1'b1;
        step("post_rst");
        check("post_rst.first_ch", 32'(bus.out_ch), 32'h0);
        step("post_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
